// File: rtl/switch_button_input_reader.sv
// Synchronizes and debounces board switches and push-buttons, and turns each button
// press into a single level request/acknowledge handshake. Optional macro: SELECT_LOCK_EN.
module switch_button_input_reader #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic switch0,
    input  logic switch1,
    input  logic btn_write,
    input  logic btn_read,
    input  logic write_ack,
    input  logic read_ack,
    output logic write_sel,
    output logic read_sel,
    output logic sel_changed,
    output logic write_req,
    output logic write_req_blk,
    output logic read_req,
    output logic read_req_blk
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } chan_state_t;

    // Bit order: 0 switch0, 1 switch1, 2 btn_write, 3 btn_read
    logic [3:0] raw;
    logic [3:0] stable;

    assign raw = {btn_read, btn_write, switch1, switch0};

    for (genvar i = 0; i < 4; i++) begin : g_input
        logic [SYNC_STAGES-1:0] chain;
        logic                   q;
        logic [CNT_W-1:0]       cnt;

        // The debounce compares against the last synchronizer stage; q only moves
        // after DEBOUNCE_CYCLES consecutive disagreeing edges.
        always_ff @(posedge clock) begin
            if (reset) begin
                chain <= '0;
                q     <= 1'b0;
                cnt   <= '0;
            end else begin
                chain <= {chain[SYNC_STAGES-2:0], raw[i]};
                if (chain[SYNC_STAGES-1] == q) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    q   <= chain[SYNC_STAGES-1];
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end

        assign stable[i] = q;
    end

    logic btn_w_d;
    logic btn_w_prev;
    logic btn_r_d;
    logic btn_r_prev;

    // Buttons are delayed to line up with the select registers, so a request
    // captures the select value that was already visible when it rose.
    always_ff @(posedge clock) begin
        if (reset) begin
            btn_w_d    <= 1'b0;
            btn_w_prev <= 1'b0;
            btn_r_d    <= 1'b0;
            btn_r_prev <= 1'b0;
        end else begin
            btn_w_d    <= stable[2];
            btn_w_prev <= btn_w_d;
            btn_r_d    <= stable[3];
            btn_r_prev <= btn_r_d;
        end
    end

    logic sel_hold;

`ifdef SELECT_LOCK_EN
    assign sel_hold = write_req | read_req;
`else
    assign sel_hold = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            write_sel   <= 1'b0;
            read_sel    <= 1'b0;
            sel_changed <= 1'b0;
        end else if (sel_hold) begin
            sel_changed <= 1'b0;
        end else begin
            write_sel   <= stable[0];
            read_sel    <= stable[1];
            sel_changed <= (stable[0] != write_sel) || (stable[1] != read_sel);
        end
    end

    chan_state_t w_state;
    chan_state_t r_state;

    always_ff @(posedge clock) begin
        if (reset) begin
            w_state       <= IDLE;
            write_req     <= 1'b0;
            write_req_blk <= 1'b0;
        end else begin
            case (w_state)
                IDLE: begin
                    if (btn_w_d && !btn_w_prev) begin
                        w_state       <= REQ;
                        write_req     <= 1'b1;
                        write_req_blk <= write_sel;
                    end
                end
                REQ: begin
                    if (write_ack) begin
                        write_req <= 1'b0;
                        w_state   <= btn_w_d ? RELEASE : IDLE;
                    end
                end
                RELEASE: begin
                    if (!btn_w_d) begin
                        w_state <= IDLE;
                    end
                end
                default: begin
                    w_state   <= IDLE;
                    write_req <= 1'b0;
                end
            endcase
        end
    end

    // Mirror of the write channel; the two handshakes never interact.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            read_req     <= 1'b0;
            read_req_blk <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (btn_r_d && !btn_r_prev) begin
                        r_state      <= REQ;
                        read_req     <= 1'b1;
                        read_req_blk <= read_sel;
                    end
                end
                REQ: begin
                    if (read_ack) begin
                        read_req <= 1'b0;
                        r_state  <= btn_r_d ? RELEASE : IDLE;
                    end
                end
                RELEASE: begin
                    if (!btn_r_d) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    read_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
